mcdf_arbiter: RTL and testbench
===============================

// Module: mcdf_arbiter
// PURPOSE
// - Arbitrates between the three MCDF slave channel FIFOs and streams one whole packet at a time into the formatter.
// - Sits between the slave FIFOs (upstream) and the formatter (downstream).
// - Presents the winning channel id (2'b11 = none ready) to the formatter.
// - On the formatter's f2a_ack pulse it streams the packet out, one word per cycle, and marks the last word with a2f_end.
// PARAMETERS
// - DW       32     data word width
// - NCH      3      channels; fixed at 3 because id 2'b11 is reserved as "none"
// PORTS
// - clk_i             in   1       single clock, rising edge
// - rstn_i            in   1       asynchronous, active-low reset
// - slv_data_i        in   NCH*DW  show-ahead FIFO head word per channel; ch i = [i*DW +: DW]
// - slv_pkg_rdy_i     in   NCH     ch i FIFO holds >= its packet length words
// - slv_pop_o         out  NCH     pop ch i head word this cycle
// - chnl_en_i         in   NCH     channel enable
// - chnl_prio_i       in   NCH*2   priority per channel; 0 = highest
// - chnl_pkglen_i     in   NCH*3   package length select per channel
// - f2a_ack_i         in   1       formatter grant ack, 1-cycle pulse
// - a2f_val_o         out  1       data word valid
// - a2f_id_o          out  2       winning/active channel; 2'b11 = none
// - a2f_data_o        out  DW      packet data word
// - a2f_pkglen_sel_o  out  3       length select of the winning/active channel
// - a2f_end_o         out  1       last word of packet
// BEHAVIOUR
// - Reset (async, rstn_i low): state IDLE, cnt=0, a2f_id_o=2'b11, a2f_pkglen_sel_o=0; all other outputs 0.
// - Length decode: 000->4, 001->8, 010->16, 011->32, 1xx->32. cnt is 6 bits.
// - IDLE:
//   - Candidates: chnl_en_i[i] & slv_pkg_rdy_i[i].
//   - Winner: lowest prio value; tie -> lowest channel index.
//   - a2f_id_o and a2f_pkglen_sel_o are registered each cycle from the winner (2'b11 and 0 if no candidate).
//     The id therefore trails the candidates by 1 cycle.
// - IDLE & f2a_ack_i & a2f_id_o!=2'b11:
//   - Latch ch=a2f_id_o and len=decode(a2f_pkglen_sel_o); cnt=0; go to SEND.
//   - If f2a_ack_i arrives while a2f_id_o==2'b11, ignore it.
// - SEND (first cycle = ack+1, aligned with the formatter's start):
//   - a2f_val_o=1; slv_pop_o[ch]=1; a2f_data_o = slv_data_i[ch] (combinational mux, zero added latency).
//   - cnt increments each cycle.
//   - a2f_end_o=1 when cnt==len-1; that cycle returns to IDLE.
// - Packet = exactly len consecutive words with no bubbles.
// - Next ack cannot occur earlier than 2 cycles after end (formatter end_d1 gap).
// - SEND holds a2f_id_o and a2f_pkglen_sel_o constant at the latched values.
//   - chnl_en_i, chnl_prio_i, chnl_pkglen_i and slv_pkg_rdy_i changes do not affect an active packet.
//   - A disabled channel finishes its current packet.
// - f2a_ack_i while in SEND: ignored.
// - In IDLE: a2f_val_o=0, a2f_end_o=0, slv_pop_o=0, a2f_data_o=0.
// - On the IDLE re-entry cycle after end, arbitration restarts.
//   - The same channel may win again (strict priority; no round-robin).
// - Reset mid-packet aborts immediately: outputs go to reset values; the FIFO state is upstream's responsibility.
// STRUCTURE
// - Package mcdf_pkg:
//   - ID_NONE=2'b11
//   - state enum {IDLE,SEND}
//   - function pkglen_decode(sel)->[5:0]; shared with the slave FIFO and formatter.
// - Sub-module mcdf_arb_prio: combinational winner select (en, rdy, prio -> id, valid).
// - Top holds the FSM, counter, latches and data mux.
// TESTING
// - Reset, then ch1 en+rdy, prio=0, pkglen=000, ack pulse:
//   - a2f_id=1 before ack.
//   - 4 valid words at ack+1..ack+4; end on word 4; pop[1] high for exactly 4 cycles.
// - All 3 ready with prio {ch0=2, ch1=1, ch2=1}:
//   - id=1 (tie -> lower index).
//   - After ch1 is disabled: id=2.
// - pkglen=101 on ch0: 32 words, end at cnt=31; a2f_pkglen_sel_o=101 throughout.
// - Mid-packet (ch2, len 16): disable ch2 and change its prio/pkglen at word 5.
//   - All 16 words still sent; id stays 2; no bubble.
// - f2a_ack_i pulsed with id=2'b11, and again during SEND:
//   - No state change; no extra pops.
// - rstn_i low at word 3 of an 8-word packet:
//   - Outputs go to reset values within the same cycle (async).
//   - After release: IDLE, id re-arbitrated.

Source files
------------

// File: rtl/mcdf_pkg.sv
// ---------------------------------------------------------------------------
// mcdf_pkg
// Shared definitions for the MCDF datapath: the reserved "no channel" id,
// the arbiter state encoding and the packet-length decode used by the slave
// FIFO, the arbiter and the formatter alike.
// ---------------------------------------------------------------------------
package mcdf_pkg;

    // Channel id reported when no channel is ready to send.
    localparam logic [1:0] ID_NONE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Packet length in words for a 3-bit length select.
    // Any select with the top bit set means the maximum length of 32 words.
    function automatic logic [5:0] pkglen_decode(input logic [2:0] sel);
        logic [5:0] len_s;
        case (sel)
            3'b000:  len_s = 6'd4;
            3'b001:  len_s = 6'd8;
            3'b010:  len_s = 6'd16;
            default: len_s = 6'd32;
        endcase
        return len_s;
    endfunction

endpackage

// File: rtl/mcdf_arb_prio.sv
// ---------------------------------------------------------------------------
// mcdf_arb_prio
// Combinational strict-priority winner select across the slave channels.
// A channel is a candidate when it is enabled and its FIFO holds a whole
// packet. The lowest priority value wins; on a tie the lowest channel index
// wins.
// Ports:
//   en    in  NCH     channel enable
//   rdy   in  NCH     channel holds a complete packet
//   prio  in  NCH*2   priority per channel, 0 = highest
//   id    out 2       winning channel (ID_NONE when valid is low)
//   valid out 1       at least one candidate exists
// ---------------------------------------------------------------------------
module mcdf_arb_prio #(
    parameter int NCH = 3
) (
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   rdy,
    input  logic [NCH*2-1:0] prio,
    output logic [1:0]       id,
    output logic             valid
);
    import mcdf_pkg::*;

    logic       found_s;
    logic [1:0] best_s;

    // Scan channels in ascending index; a strict less-than keeps the lower
    // index on a priority tie.
    always_comb begin
        found_s = 1'b0;
        best_s  = 2'b11;
        id      = ID_NONE;
        for (int i = 0; i < NCH; i++) begin
            if (en[i] && rdy[i] && (!found_s || (prio[i*2 +: 2] < best_s))) begin
                found_s = 1'b1;
                best_s  = prio[i*2 +: 2];
                id      = 2'(i);
            end else begin
                found_s = found_s;
            end
        end
        valid = found_s;
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// ---------------------------------------------------------------------------
// mcdf_arbiter
// Picks one of the slave channel FIFOs and streams a whole packet from it to
// the formatter, one word per cycle, after the formatter acknowledges the
// offered channel.
// Ports:
//   clk_i             in  1       clock, rising edge
//   rstn_i            in  1       asynchronous active-low reset
//   slv_data_i        in  NCH*DW  show-ahead FIFO head word, ch i = [i*DW +: DW]
//   slv_pkg_rdy_i     in  NCH     channel FIFO holds a complete packet
//   slv_pop_o         out NCH     pop the channel's head word this cycle
//   chnl_en_i         in  NCH     channel enable
//   chnl_prio_i       in  NCH*2   channel priority, 0 = highest
//   chnl_pkglen_i     in  NCH*3   channel packet length select
//   f2a_ack_i         in  1       formatter accepts the offered channel
//   a2f_val_o         out 1       data word valid
//   a2f_id_o          out 2       offered/active channel, 2'b11 = none
//   a2f_data_o        out DW      packet data word
//   a2f_pkglen_sel_o  out 3       length select of offered/active channel
//   a2f_end_o         out 1       last word of the packet
// ---------------------------------------------------------------------------
module mcdf_arbiter #(
    parameter int DW  = 32,
    parameter int NCH = 3
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NCH*DW-1:0] slv_data_i,
    input  logic [NCH-1:0]    slv_pkg_rdy_i,
    output logic [NCH-1:0]    slv_pop_o,
    input  logic [NCH-1:0]    chnl_en_i,
    input  logic [NCH*2-1:0]  chnl_prio_i,
    input  logic [NCH*3-1:0]  chnl_pkglen_i,
    input  logic              f2a_ack_i,
    output logic              a2f_val_o,
    output logic [1:0]        a2f_id_o,
    output logic [DW-1:0]     a2f_data_o,
    output logic [2:0]        a2f_pkglen_sel_o,
    output logic              a2f_end_o
);
    import mcdf_pkg::*;

    state_e     state_r;
    state_e     state_nxt_s;
    logic [5:0] cnt_r;
    logic [5:0] len_r;
    logic [1:0] id_r;
    logic [2:0] sel_r;

    logic [1:0] win_id_s;
    logic       win_vld_s;
    logic [2:0] win_sel_s;
    logic       start_s;
    logic       last_s;

    mcdf_arb_prio #(
        .NCH (NCH)
    ) u_prio (
        .en    (chnl_en_i),
        .rdy   (slv_pkg_rdy_i),
        .prio  (chnl_prio_i),
        .id    (win_id_s),
        .valid (win_vld_s)
    );

    // Length select of the current winner, zero when nobody is ready.
    always_comb begin
        win_sel_s = 3'b000;
        for (int i = 0; i < NCH; i++) begin
            if (win_vld_s && (win_id_s == 2'(i))) begin
                win_sel_s = chnl_pkglen_i[i*3 +: 3];
            end else begin
                win_sel_s = win_sel_s;
            end
        end
    end

    // An ack only counts while a real channel is on offer.
    assign start_s = (state_r == IDLE) && f2a_ack_i && (id_r != ID_NONE);
    assign last_s  = (state_r == SEND) && (cnt_r == (len_r - 6'd1));

    // Next-state selection for the packet FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Packet FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Word counter and latched packet length for the active packet.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_r <= 6'd0;
            len_r <= 6'd0;
        end else if (start_s) begin
            cnt_r <= 6'd0;
            len_r <= pkglen_decode(sel_r);
        end else if (state_r == SEND) begin
            cnt_r <= last_s ? 6'd0 : (cnt_r + 6'd1);
        end else begin
            cnt_r <= 6'd0;
        end
    end

    // Offered channel id and length select. They follow the arbiter while
    // idle and freeze from the accepted ack until the packet ends, so the
    // id register doubles as the active channel during SEND.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            id_r  <= ID_NONE;
            sel_r <= 3'b000;
        end else if ((state_r == IDLE) && !start_s) begin
            id_r  <= win_vld_s ? win_id_s : ID_NONE;
            sel_r <= win_sel_s;
        end else begin
            id_r  <= id_r;
            sel_r <= sel_r;
        end
    end

    // Streaming outputs: the active FIFO's head word passes straight through
    // so every SEND cycle carries a word with no added latency.
    always_comb begin
        a2f_val_o  = 1'b0;
        a2f_end_o  = 1'b0;
        slv_pop_o  = '0;
        a2f_data_o = '0;
        if (state_r == SEND) begin
            a2f_val_o = 1'b1;
            a2f_end_o = last_s;
            for (int i = 0; i < NCH; i++) begin
                if (id_r == 2'(i)) begin
                    slv_pop_o[i] = 1'b1;
                    a2f_data_o   = slv_data_i[i*DW +: DW];
                end else begin
                    slv_pop_o[i] = 1'b0;
                end
            end
        end else begin
            a2f_val_o = 1'b0;
        end
    end

    assign a2f_id_o         = id_r;
    assign a2f_pkglen_sel_o = sel_r;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mcdf_arbiter
// Self-checking bench for mcdf_arbiter: a packet-level reference model runs
// alongside the DUT every cycle, a table of arbitration vectors checks the
// winner selection, and short directed sequences cover the multi-cycle
// corner cases before a randomized soak.
// ---------------------------------------------------------------------------
module tb_mcdf_arbiter;

    localparam int DW  = 32;
    localparam int NCH = 3;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [NCH*DW-1:0] slv_data_i;
    logic [NCH-1:0]    slv_pkg_rdy_i;
    logic [NCH-1:0]    slv_pop_o;
    logic [NCH-1:0]    chnl_en_i;
    logic [NCH*2-1:0]  chnl_prio_i;
    logic [NCH*3-1:0]  chnl_pkglen_i;
    logic              f2a_ack_i;
    logic              a2f_val_o;
    logic [1:0]        a2f_id_o;
    logic [DW-1:0]     a2f_data_o;
    logic [2:0]        a2f_pkglen_sel_o;
    logic              a2f_end_o;

    always #5 clk_i = ~clk_i;

    mcdf_arbiter #(
        .DW  (DW),
        .NCH (NCH)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .slv_data_i       (slv_data_i),
        .slv_pkg_rdy_i    (slv_pkg_rdy_i),
        .slv_pop_o        (slv_pop_o),
        .chnl_en_i        (chnl_en_i),
        .chnl_prio_i      (chnl_prio_i),
        .chnl_pkglen_i    (chnl_pkglen_i),
        .f2a_ack_i        (f2a_ack_i),
        .a2f_val_o        (a2f_val_o),
        .a2f_id_o         (a2f_id_o),
        .a2f_data_o       (a2f_data_o),
        .a2f_pkglen_sel_o (a2f_pkglen_sel_o),
        .a2f_end_o        (a2f_end_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: packet-level view of the arbiter.
    bit         m_busy;
    int         m_ch;
    int         m_len;
    int         m_idx;
    logic [1:0] m_id;
    logic [2:0] m_sel;
    int         since_end;
    int         pop_count;
    int         end_count;

    typedef struct {
        logic [2:0] en;
        logic [2:0] rdy;
        logic [5:0] prio;
        logic [8:0] pkglen;
        logic [1:0] exp_id;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_len(input logic [2:0] s);
        if (s[2]) return 32;
        return 4 << s[1:0];
    endfunction

    // Winner from the rules: first enabled+ready channel at the best priority level.
    task automatic ref_winner(output logic [1:0] id, output logic [2:0] sel);
        bit found;
        found = 1'b0;
        id    = 2'b11;
        sel   = 3'b000;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!found && chnl_en_i[c] && slv_pkg_rdy_i[c] && (int'(chnl_prio_i[c*2 +: 2]) == p)) begin
                    found = 1'b1;
                    id    = 2'(c);
                    sel   = chnl_pkglen_i[c*3 +: 3];
                end
            end
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_ch      = 0;
        m_len     = 0;
        m_idx     = 0;
        m_id      = 2'b11;
        m_sel     = 3'b000;
        since_end = 10;
    endtask

    task automatic model_step();
        if (m_busy) begin
            m_idx++;
            if (m_idx == m_len) begin
                m_busy    = 1'b0;
                since_end = 0;
            end
        end else begin
            since_end++;
            if (f2a_ack_i && (m_id != 2'b11)) begin
                m_busy = 1'b1;
                m_ch   = int'(m_id);
                m_len  = ref_len(m_sel);
                m_idx  = 0;
            end else begin
                ref_winner(m_id, m_sel);
            end
        end
    endtask

    // One clock: fresh FIFO head words, compare all outputs to the model,
    // then advance the model on the rising edge. Starts and ends at negedge.
    task automatic tick();
        logic [NCH-1:0] e_pop;
        logic [DW-1:0]  e_data;
        slv_data_i = {$urandom, $urandom, $urandom};
        #1;
        e_pop  = m_busy ? 3'(1 << m_ch) : 3'b000;
        e_data = m_busy ? slv_data_i[m_ch*DW +: DW] : 32'h0;
        check("val",  32'(a2f_val_o), 32'(m_busy));
        check("end",  32'(a2f_end_o), 32'(m_busy && (m_idx == m_len - 1)));
        check("pop",  32'(slv_pop_o), 32'(e_pop));
        check("data", a2f_data_o, e_data);
        check("id",   32'(a2f_id_o), 32'(m_id));
        check("sel",  32'(a2f_pkglen_sel_o), 32'(m_sel));
        pop_count += $countones(slv_pop_o);
        end_count += int'(a2f_end_o);
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rstn_i = 1'b0;
        #1;
        check("rst_val", 32'(a2f_val_o), 32'd0);
        check("rst_end", 32'(a2f_end_o), 32'd0);
        check("rst_pop", 32'(slv_pop_o), 32'd0);
        check("rst_data", a2f_data_o, 32'd0);
        check("rst_id",  32'(a2f_id_o), 32'd3);
        check("rst_sel", 32'(a2f_pkglen_sel_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic pulse_ack();
        f2a_ack_i = 1'b1;
        tick();
        f2a_ack_i = 1'b0;
    endtask

    initial begin
        rstn_i        = 1'b0;
        slv_data_i    = '0;
        slv_pkg_rdy_i = '0;
        chnl_en_i     = '0;
        chnl_prio_i   = '0;
        chnl_pkglen_i = '0;
        f2a_ack_i     = 1'b0;
        pop_count     = 0;
        end_count     = 0;
        model_reset();
        @(negedge clk_i);
        do_reset();

        // Arbitration table: prio/pkglen packed {ch2, ch1, ch0}.
        vecs[0] = '{3'b111, 3'b111, 6'b01_01_10, 9'b010_001_000, 2'd1, 3'b001};
        vecs[1] = '{3'b101, 3'b111, 6'b01_01_10, 9'b010_001_000, 2'd2, 3'b010};
        vecs[2] = '{3'b111, 3'b000, 6'b00_00_00, 9'b010_001_000, 2'd3, 3'b000};
        vecs[3] = '{3'b111, 3'b111, 6'b00_00_00, 9'b010_001_000, 2'd0, 3'b000};
        vecs[4] = '{3'b110, 3'b011, 6'b00_11_00, 9'b010_001_000, 2'd1, 3'b001};
        vecs[5] = '{3'b111, 3'b111, 6'b00_11_11, 9'b100_011_111, 2'd2, 3'b100};
        vecs[6] = '{3'b011, 3'b111, 6'b00_10_10, 9'b100_011_111, 2'd0, 3'b111};
        for (int v = 0; v < 7; v++) begin
            chnl_en_i     = vecs[v].en;
            slv_pkg_rdy_i = vecs[v].rdy;
            chnl_prio_i   = vecs[v].prio;
            chnl_pkglen_i = vecs[v].pkglen;
            tick();
            tick();
            check($sformatf("tbl_id[%0d]", v), 32'(a2f_id_o), 32'(vecs[v].exp_id));
            check($sformatf("tbl_sel[%0d]", v), 32'(a2f_pkglen_sel_o), 32'(vecs[v].exp_sel));
        end

        // ch1 alone, length 4.
        chnl_en_i = 3'b010; slv_pkg_rdy_i = 3'b010;
        chnl_prio_i = 6'b11_00_11; chnl_pkglen_i = 9'b000_000_000;
        tick(); tick();
        check("ch1_id_before_ack", 32'(a2f_id_o), 32'd1);
        pulse_ack();
        pop_count = 0; end_count = 0;
        repeat (6) tick();
        check("ch1_pops", 32'(pop_count), 32'd4);
        check("ch1_ends", 32'(end_count), 32'd1);

        // ch0, select 101 -> 32 words.
        chnl_en_i = 3'b001; slv_pkg_rdy_i = 3'b001;
        chnl_prio_i = 6'b00_00_00; chnl_pkglen_i = 9'b000_000_101;
        tick(); tick();
        check("len32_sel", 32'(a2f_pkglen_sel_o), 32'd5);
        pulse_ack();
        pop_count = 0; end_count = 0;
        repeat (34) tick();
        check("len32_pops", 32'(pop_count), 32'd32);
        check("len32_ends", 32'(end_count), 32'd1);

        // ch2 length 16, configuration yanked away at word 5.
        chnl_en_i = 3'b100; slv_pkg_rdy_i = 3'b100;
        chnl_prio_i = 6'b00_00_00; chnl_pkglen_i = 9'b010_000_000;
        tick(); tick();
        pulse_ack();
        pop_count = 0;
        repeat (4) tick();
        chnl_en_i = 3'b000; slv_pkg_rdy_i = 3'b000;
        chnl_prio_i = 6'b11_00_00; chnl_pkglen_i = 9'b000_000_000;
        repeat (14) tick();
        check("midchg_pops", 32'(pop_count), 32'd16);

        // Ack with nothing offered, then ack during SEND.
        tick(); tick();
        pop_count = 0;
        pulse_ack();
        tick(); tick();
        check("ack_none_pops", 32'(pop_count), 32'd0);
        chnl_en_i = 3'b010; slv_pkg_rdy_i = 3'b010; chnl_pkglen_i = 9'b000_000_000;
        tick(); tick();
        pulse_ack();
        pop_count = 0;
        tick();
        pulse_ack();
        repeat (6) tick();
        check("ack_send_pops", 32'(pop_count), 32'd4);

        // Reset during word 3 of an 8-word packet.
        chnl_pkglen_i = 9'b000_001_000;
        tick(); tick();
        pulse_ack();
        tick(); tick();
        check("pre_rst_val", 32'(a2f_val_o), 32'd1);
        do_reset();
        tick(); tick();
        check("post_rst_id", 32'(a2f_id_o), 32'd1);

        // Randomized soak against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                chnl_en_i     = 3'($urandom);
                slv_pkg_rdy_i = 3'($urandom);
                chnl_prio_i   = 6'($urandom);
                chnl_pkglen_i = 9'($urandom);
            end
            if (m_busy) begin
                f2a_ack_i = ($urandom_range(0, 7) == 0);
            end else begin
                f2a_ack_i = (since_end >= 1) && ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        f2a_ack_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
